// File: rtl/matrix_vec_mac3x3.sv
// 3x3 fixed-point matrix-vector multiply stage: one time-multiplexed MAC walks
// the nine products, rounds/saturates each row, and hands the vector downstream.
module matrix_vec_mac3x3 #(
  parameter int unsigned DW   = 16,
  parameter int unsigned CW   = 16,
  parameter int unsigned FRAC = 14
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            coef_we_i,
  input  logic [3:0]      coef_addr_i,
  input  logic [CW-1:0]   coef_wdata_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3*DW-1:0] in_vec_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [3*DW-1:0] out_vec_o,
  output logic            busy_o
);

  localparam int unsigned PW = DW + CW;
  localparam int unsigned AW = PW + 2;
  localparam logic signed [AW-1:0] RND     = AW'(1) << (FRAC - 1);
  localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) << (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN = -(AW'(1) << (DW - 1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic logic [CW-1:0] ident(input int unsigned i);
    return (i % 4 == 0) ? (CW'(1) << FRAC) : '0;
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             row_q, row_d, col_q, col_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]   x_q [3];
  logic signed [DW-1:0]   x_d [3];
  logic signed [DW-1:0]   res_q [3];
  logic signed [DW-1:0]   res_d [3];
  logic signed [CW-1:0]   shadow_q [9];
  logic signed [CW-1:0]   shadow_d [9];
  logic signed [CW-1:0]   active_q [9];
  logic signed [CW-1:0]   active_d [9];
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [3:0]             idx;
  logic signed [DW-1:0]   x_sel;
  logic signed [CW-1:0]   a_sel;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW-1:0]   rounded;
  logic signed [DW-1:0]   res_sat;

  // Current product, running sum and the rounded/saturated row result.
  always_comb begin
    idx     = 4'(row_q) * 4'd3 + 4'(col_q);
    x_sel   = x_q[col_q];
    a_sel   = active_q[idx];
    prod    = PW'(x_sel) * PW'(a_sel);
    acc_sum = acc_q + AW'(prod);
    rounded = (acc_sum + RND) >>> FRAC;
    if (rounded > SAT_MAX)      res_sat = DW'(SAT_MAX);
    else if (rounded < SAT_MIN) res_sat = DW'(SAT_MIN);
    else                        res_sat = DW'(rounded);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = MAC;
      MAC:     if (row_q == 2'd2 && col_q == 2'd2) state_d = OUT;
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    x_d         = x_q;
    res_d       = res_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d == MAC) || (state_d == OUT);

    if (coef_we_i && coef_addr_i < 4'd9) shadow_d[coef_addr_i] = coef_wdata_i;

    // Snapshot of the pre-write shadow bank travels with the accepted vector.
    if (state_q == IDLE && in_valid_i) begin
      active_d = shadow_q;
      for (int i = 0; i < 3; i++) x_d[i] = in_vec_i[i*DW +: DW];
      row_d = 2'd0;
      col_d = 2'd0;
      acc_d = '0;
    end

    if (state_q == MAC) begin
      if (col_q == 2'd2) begin
        res_d[row_q] = res_sat;
        acc_d        = '0;
        col_d        = 2'd0;
        row_d        = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
      end else begin
        acc_d = acc_sum;
        col_d = col_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        x_q[i]   <= '0;
        res_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 9; i++) begin
        shadow_q[i] <= ident(i);
        active_q[i] <= ident(i);
      end
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      res_q       <= res_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign out_vec_o   = {res_q[2], res_q[1], res_q[0]};

endmodule
